hash_req_arbiter: RTL and testbench

Shares one hash-table command port (axi_wrapper) among NUM_REQ independent requesters. Round-robin arbitrates incoming commands {op, key, data} into a registered issue slot. Tags every issued command with its requester ID in an in-order tag FIFO. Uses the head tag to steer each table response back to the requester that issued the command.

---
 rtl/hash_arb_pkg.sv | 25 ++
 rtl/hash_arb_tag_fifo.sv | 52 +++++
 rtl/hash_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_hash_req_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hash_arb_pkg.sv
// Shared types and helpers for hash_req_arbiter: command opcodes, command width
// and the requester-ID type used for response steering tags.
package hash_arb_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_LOOKUP = 2'b01,
    OP_INSERT = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int REQ_ID_W    = (DEF_NUM_REQ > 1) ? $clog2(DEF_NUM_REQ) : 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  function automatic int cmd_width(input int key_width, input int data_width);
    return 2 + key_width + data_width;
  endfunction

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/hash_arb_tag_fifo.sv
// In-order FIFO of requester IDs; one tag per issued table command.
// DEPTH must be a power of two so the pointers wrap naturally.
module hash_arb_tag_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/hash_req_arbiter.sv
// Round-robin sharing of one hash-table command port among NUM_REQ requesters,
// with in-order tag steering of responses. Optional HASH_ARB_STATS_EN adds counters.
module hash_req_arbiter
  import hash_arb_pkg::*;
#(
  parameter  int KEY_WIDTH    = 32,
  parameter  int DATA_WIDTH   = 30,
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_INFLIGHT = 8,
  localparam int CMD_W        = cmd_width(KEY_WIDTH, DATA_WIDTH),
  localparam int IDW          = id_width(NUM_REQ),
  localparam int CW           = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][CMD_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [CMD_W-1:0]                rsp_data_o,
  output logic                            tbl_valid_o,
  output logic [CMD_W-1:0]                tbl_data_o,
  input  logic                            tbl_ready_i,
  input  logic                            tbl_valid_i,
  input  logic [CMD_W-1:0]                tbl_data_i,
  output logic                            tbl_ready_o,
  output logic                            err_o
`ifdef HASH_ARB_STATS_EN
  ,
  output logic [31:0]                     stat_issued_o,
  output logic [31:0]                     stat_stall_o
`endif
);

  localparam logic [IDW:0]   NREQ = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]  rr, winner, head;
  logic            found, grant, push, pop;
  logic            slot_vld, slot_free, win_nop;
  logic [CMD_W-1:0] slot_data, win_cmd;
  logic            tag_full, tag_empty, tag_any;
  logic [CW-1:0]   tag_count;
  op_e             win_op;

  // First valid requester at or after rr, scanning with wrap.
  always_comb begin
    logic [IDW:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr} + (IDW+1)'(i);
      if (sum >= NREQ) sum = sum - NREQ;
      if (!found && req_valid_i[sum[IDW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IDW-1:0];
      end
    end
  end

  assign win_cmd   = req_data_i[winner];
  assign win_op    = op_e'(win_cmd[CMD_W-1 -: 2]);
  assign win_nop   = (win_op == OP_NOP);
  assign slot_free = !slot_vld || tbl_ready_i;
  // NOPs never occupy a tag, so a full FIFO does not block them.
  assign grant     = found && slot_free && (win_nop || !tag_full);
  assign push      = grant && !win_nop;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= '0;
      slot_vld  <= 1'b0;
      slot_data <= '0;
    end else begin
      if (grant) rr <= (winner == LAST) ? '0 : winner + IDW'(1);
      if (push) begin
        slot_vld  <= 1'b1;
        slot_data <= win_cmd;
      end else if (tbl_ready_i) begin
        slot_vld  <= 1'b0;
      end
    end
  end

  assign tbl_valid_o = slot_vld;
  assign tbl_data_o  = slot_data;

  hash_arb_tag_fifo #(
    .W     (IDW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (winner),
    .pop   (pop),
    .dout  (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign tag_any    = (tag_count != '0);
  assign rsp_data_o = tbl_data_i;

  // With no outstanding tag the response has no owner: accept and drop it.
  always_comb begin
    rsp_valid_o = '0;
    tbl_ready_o = 1'b1;
    pop         = 1'b0;
    if (tag_any) begin
      rsp_valid_o[head] = tbl_valid_i;
      tbl_ready_o       = rsp_ready_i[head];
      pop               = tbl_valid_i && rsp_ready_i[head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_o <= 1'b0;
    else if (tag_empty && tbl_valid_i) err_o <= 1'b1;
  end

`ifdef HASH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (tbl_valid_o && tbl_ready_i) stat_issued_o <= stat_issued_o + 32'd1;
      if (|req_valid_i && !grant)     stat_stall_o  <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Bench for hash_req_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_hash_req_arbiter;

  localparam int NR = 4;
  localparam int CW = 64;
  localparam int MI = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR-1:0][CW-1:0] req_data;
  logic [CW-1:0]        rsp_data, tbl_data_out, tbl_data_in;
  logic                 tbl_valid_out, tbl_ready, tbl_valid_in, tbl_ready_out, err;
`ifdef HASH_ARB_STATS_EN
  logic [31:0]          stat_issued, stat_stall;
`endif

  hash_req_arbiter #(
    .KEY_WIDTH(32), .DATA_WIDTH(30), .NUM_REQ(NR), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .tbl_valid_o(tbl_valid_out), .tbl_data_o(tbl_data_out), .tbl_ready_i(tbl_ready),
    .tbl_valid_i(tbl_valid_in), .tbl_data_i(tbl_data_in), .tbl_ready_o(tbl_ready_out),
    .err_o(err)
`ifdef HASH_ARB_STATS_EN
    , .stat_issued_o(stat_issued), .stat_stall_o(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] op, input int k);
    return {op, 32'(k), 30'(k)};
  endfunction

  task automatic idle();
    req_valid = '0; rsp_ready = '0; tbl_ready = 1'b0; tbl_valid_in = 1'b0; tbl_data_in = '0;
    for (int r = 0; r < NR; r++) req_data[r] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] nop;
    logic       tr;
    logic [3:0] ready;
    logic       tvalid;
    int         key;
  } vec_t;

  vec_t vt[10];
  logic [3:0] exp_rv [5];

  // reference model state
  int       m_rr, w, h, j;
  bit       m_sv, m_err, isnop, gnt;
  logic [63:0] m_sd;
  int       q[$];
  logic [3:0] e_ready, e_rv;
  logic     e_tr;

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst tbl_valid", 64'(tbl_valid_out), 64'd0);
    chk("rst tbl_data", tbl_data_out, 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // cycle vectors: per requester r, key = r+1, LOOKUP unless nop bit set
    vt[0] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 0};
    vt[1] = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 1};
    vt[2] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2};
    vt[3] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 2};
    vt[4] = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1, 4};
    vt[5] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 4};
    vt[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0};
    vt[7] = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b0, 0};
    vt[8] = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 1};
    vt[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 3};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = vt[i].v;
      tbl_ready = vt[i].tr;
      for (int r = 0; r < NR; r++) req_data[r] = mk(vt[i].nop[r] ? 2'b00 : 2'b01, r + 1);
      #1;
      chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(vt[i].ready));
      chk($sformatf("vec%0d tvalid", i), 64'(tbl_valid_out), 64'(vt[i].tvalid));
      if (vt[i].tvalid) chk($sformatf("vec%0d tdata", i), tbl_data_out, mk(2'b01, vt[i].key));
    end

    // responses steered in issue order: r0,r1,r3,r0,r2; first with head not ready
    @(negedge clk);
    idle(); tbl_valid_in = 1'b1; tbl_data_in = 64'hABCD_0000_1234_5678; rsp_ready = 4'b1110;
    #1;
    chk("stall rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("stall tbl_ready", 64'(tbl_ready_out), 64'd0);
    exp_rv[0] = 4'b0001; exp_rv[1] = 4'b0010; exp_rv[2] = 4'b1000;
    exp_rv[3] = 4'b0001; exp_rv[4] = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rsp_ready = 4'b1111; tbl_data_in = 64'(i) * 64'h1111_0000_0101;
      #1;
      chk($sformatf("route%0d rsp_valid", i), 64'(rsp_valid), 64'(exp_rv[i]));
      chk($sformatf("route%0d rsp_data", i), rsp_data, 64'(i) * 64'h1111_0000_0101);
      chk($sformatf("route%0d tbl_ready", i), 64'(tbl_ready_out), 64'd1);
    end
    @(negedge clk);
    idle(); rsp_ready = 4'b1111;
    #1;
    chk("drained tbl_ready", 64'(tbl_ready_out), 64'd1);
    chk("drained err", 64'(err), 64'd0);

    // tag FIFO full: 8 issues, then stall; a same-cycle pop does not free space
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = 4'b0001; req_data[0] = mk(2'b01, i); tbl_ready = 1'b1;
      tbl_valid_in = (i == 10); rsp_ready = 4'b0001;
      #1;
      chk($sformatf("full%0d ready", i), 64'(req_ready), (i < 8 || i == 11) ? 64'd1 : 64'd0);
    end

    // held slot: tbl_ready low keeps data stable and blocks grants
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_data[1] = mk(2'b10, 7); tbl_ready = 1'b0;
    #1; chk("hold grant", 64'(req_ready), 64'b0010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 4'b0100; req_data[1] = '0; req_data[2] = mk(2'b01, 9);
      #1;
      chk($sformatf("hold%0d ready", i), 64'(req_ready), 64'd0);
      chk($sformatf("hold%0d tdata", i), tbl_data_out, mk(2'b10, 7));
    end
    @(negedge clk);
    tbl_ready = 1'b1;
    #1;
`ifdef HASH_ARB_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'd3);
    chk("stat_issued", 64'(stat_issued), 64'd0);
`endif
    chk("hold release ready", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = 4'b0001; req_data[0] = mk(2'b11, 8);

    // reset with three commands in flight; late response must set err
    @(negedge clk);
    idle(); rst_n = 1'b0;
    #1;
    chk("mid rst tbl_valid", 64'(tbl_valid_out), 64'd0);
    chk("mid rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid rst err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; tbl_valid_in = 1'b1; tbl_data_in = 64'h55; rsp_ready = 4'b1111;
    #1;
    chk("orphan tbl_ready", 64'(tbl_ready_out), 64'd1);
    chk("orphan rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    idle();
    #1; chk("err set", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    #1; chk("err sticky", 64'(err), 64'd1);

    // randomized run against the reference model
    do_reset();
    m_rr = 0; m_sv = 0; m_sd = '0; m_err = 0; q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      for (int r = 0; r < NR; r++) req_data[r] = {2'($urandom_range(0, 3)), 32'($urandom), 30'($urandom)};
      tbl_ready    = ($urandom_range(0, 3) != 0);
      tbl_valid_in = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      tbl_data_in  = {$urandom, $urandom};
      rsp_ready    = 4'($urandom);
      w = -1;
      for (int i = 0; i < NR; i++) begin
        j = (m_rr + i) % NR;
        if (w < 0 && req_valid[j]) w = j;
      end
      isnop   = (w >= 0) && (req_data[(w < 0) ? 0 : w][63:62] == 2'b00);
      gnt     = (w >= 0) && (!m_sv || tbl_ready) && (isnop || q.size() < MI);
      e_ready = gnt ? 4'(1 << w) : 4'd0;
      if (q.size() == 0) begin
        h = -1; e_rv = '0; e_tr = 1'b1;
      end else begin
        h = q[0]; e_rv = tbl_valid_in ? 4'(1 << h) : 4'd0; e_tr = rsp_ready[h];
      end
      #1;
      chk($sformatf("rnd%0d ready", c), 64'(req_ready), 64'(e_ready));
      chk($sformatf("rnd%0d tvalid", c), 64'(tbl_valid_out), 64'(m_sv));
      if (m_sv) chk($sformatf("rnd%0d tdata", c), tbl_data_out, m_sd);
      chk($sformatf("rnd%0d rsp_valid", c), 64'(rsp_valid), 64'(e_rv));
      chk($sformatf("rnd%0d tbl_ready", c), 64'(tbl_ready_out), 64'(e_tr));
      chk($sformatf("rnd%0d rsp_data", c), rsp_data, tbl_data_in);
      chk($sformatf("rnd%0d err", c), 64'(err), 64'(m_err));
      @(posedge clk);
      if (h >= 0 && tbl_valid_in && rsp_ready[h]) void'(q.pop_front());
      if (gnt && !isnop) begin
        q.push_back(w); m_sv = 1'b1; m_sd = req_data[w];
      end else if (tbl_ready) begin
        m_sv = 1'b0;
      end
      if (gnt) m_rr = (w + 1) % NR;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
